mem_lsu_stage: RTL and testbench

Memory-access stage directly downstream of the ALU in the RV32I pipeline. Takes the ALU result as an effective address (or as a pass-through result for non-memory ops), performs byte/half/word alignment and sign/zero extension, and drives a single-outstanding req/ack handshake to data memory. Stalls the upstream pipeline while a memory transaction is in flight, and presents one registered writeback beat per accepted instruction.

---
 rtl/mem_lsu_stage_if.sv | 22 ++
 rtl/mem_lsu_stage.sv | 166 ++++++++++++++++
 tb/tb_mem_lsu_stage.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_lsu_stage_if.sv
// Data-memory request/acknowledge bus between the LSU stage (master) and memory (slave).
interface mem_lsu_stage_if #(
  parameter int unsigned BW = 32
);
  logic          mem_req;
  logic          mem_we;
  logic [BW-1:0] mem_addr;
  logic [3:0]    mem_wstrb;
  logic [BW-1:0] mem_wdata;
  logic          mem_ack;
  logic [BW-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_lsu_stage.sv
// RV32I memory-access stage: alignment, lane steering, load extension, single-outstanding req/ack.
// Define MISALIGN_TRAP_EN to flag misaligned accesses instead of forcing them to alignment.
module mem_lsu_stage #(
  parameter int unsigned BW = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ex_valid,
  input  logic          ex_is_load,
  input  logic          ex_is_store,
  input  logic [2:0]    ex_funct3,
  input  logic [BW-1:0] ex_alu_res,
  input  logic [BW-1:0] ex_store_data,
  input  logic [4:0]    ex_rd,
  input  logic          ex_wb_en,
  output logic          stall,
  mem_lsu_stage_if.master mem,
  output logic          wb_valid,
  output logic          wb_en,
  output logic [4:0]    wb_rd,
  output logic [BW-1:0] wb_data,
  output logic          misalign
);

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  state_t        state;
  size_t         ex_size;
  logic          ex_uns;
  logic          ex_is_mem;
  logic          ex_mis;
  logic [1:0]    ex_off;
  logic [3:0]    ex_strb;
  logic [BW-1:0] ex_wdata;

  size_t         q_size;
  logic          q_uns;
  logic [1:0]    q_off;
  logic [4:0]    q_rd;
  logic          q_wb_en;
  logic          q_load;
  logic [BW-1:0] ld_shift;
  logic [BW-1:0] ld_data;

  // Stall depends on state only so memory ack never feeds back into the upstream hold.
  assign stall = (state == BUSY);

  // Decode access size, alignment and store lane steering from the EX inputs.
  always_comb begin
    ex_size   = SZ_W;
    ex_uns    = 1'b0;
    ex_is_mem = ex_is_load | ex_is_store;
    ex_off    = 2'b00;
    ex_strb   = 4'b1111;
    ex_wdata  = ex_store_data;
    case (ex_funct3)
      3'b000, 3'b100: ex_size = SZ_B;
      3'b001, 3'b101: ex_size = SZ_H;
      default:        ex_size = SZ_W;
    endcase
    ex_uns = (ex_funct3 == 3'b100) || (ex_funct3 == 3'b101);
    ex_mis = ((ex_size == SZ_H) && ex_alu_res[0]) ||
             ((ex_size == SZ_W) && (ex_alu_res[1:0] != 2'b00));
    case (ex_size)
      SZ_B: begin
        ex_off   = ex_alu_res[1:0];
        ex_strb  = 4'(4'b0001 << ex_off);
        ex_wdata = {4{ex_store_data[7:0]}};
      end
      SZ_H: begin
        ex_off   = {ex_alu_res[1], 1'b0};
        ex_strb  = 4'(4'b0011 << ex_off);
        ex_wdata = {2{ex_store_data[15:0]}};
      end
      default: begin
        ex_off   = 2'b00;
        ex_strb  = 4'b1111;
        ex_wdata = ex_store_data;
      end
    endcase
  end

  // Load extraction from the returned word using the latched size/offset.
  always_comb begin
    ld_shift = mem.mem_rdata >> {q_off, 3'b000};
    case (q_size)
      SZ_B:    ld_data = q_uns ? {{(BW-8){1'b0}}, ld_shift[7:0]}
                               : {{(BW-8){ld_shift[7]}}, ld_shift[7:0]};
      SZ_H:    ld_data = q_uns ? {{(BW-16){1'b0}}, ld_shift[15:0]}
                               : {{(BW-16){ld_shift[15]}}, ld_shift[15:0]};
      default: ld_data = ld_shift;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wstrb <= 4'b0000;
      mem.mem_wdata <= '0;
      wb_valid      <= 1'b0;
      wb_en         <= 1'b0;
      wb_rd         <= 5'd0;
      wb_data       <= '0;
      misalign      <= 1'b0;
      q_size        <= SZ_W;
      q_uns         <= 1'b0;
      q_off         <= 2'b00;
      q_rd          <= 5'd0;
      q_wb_en       <= 1'b0;
      q_load        <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      wb_en    <= 1'b0;
      misalign <= 1'b0;
      if (state == IDLE) begin
        if (ex_valid) begin
          if (!ex_is_mem) begin
            wb_valid <= 1'b1;
            wb_en    <= ex_wb_en;
            wb_rd    <= ex_rd;
            wb_data  <= ex_alu_res;
          end else if (TRAP_EN && ex_mis) begin
            // Trapped access: report via a non-writing beat, memory is never touched.
            wb_valid <= 1'b1;
            wb_rd    <= ex_rd;
            wb_data  <= ex_alu_res;
            misalign <= 1'b1;
          end else begin
            state         <= BUSY;
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= ex_is_store;
            mem.mem_addr  <= {ex_alu_res[BW-1:2], 2'b00};
            mem.mem_wstrb <= ex_is_store ? ex_strb : 4'b0000;
            mem.mem_wdata <= ex_wdata;
            q_size        <= ex_size;
            q_uns         <= ex_uns;
            q_off         <= ex_off;
            q_rd          <= ex_rd;
            q_wb_en       <= ex_wb_en & ex_is_load;
            q_load        <= ex_is_load;
          end
        end
      end else if (mem.mem_ack) begin
        state         <= IDLE;
        mem.mem_req   <= 1'b0;
        mem.mem_we    <= 1'b0;
        mem.mem_wstrb <= 4'b0000;
        wb_valid      <= 1'b1;
        wb_en         <= q_wb_en;
        wb_rd         <= q_rd;
        wb_data       <= q_load ? ld_data : '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_lsu_stage.sv
// Randomized self-checking bench for mem_lsu_stage against an arithmetic reference model.
module tb_mem_lsu_stage;

  logic        clock;
  logic        reset;
  logic        ex_valid;
  logic        ex_is_load;
  logic        ex_is_store;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_alu_res;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_wb_en;
  logic        stall;
  logic        wb_valid;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign;

  int n_checks = 0;
  int n_errors = 0;

  mem_lsu_stage_if #(.BW(32)) mif ();

  mem_lsu_stage #(.BW(32)) dut (
    .clock         (clock),
    .reset         (reset),
    .ex_valid      (ex_valid),
    .ex_is_load    (ex_is_load),
    .ex_is_store   (ex_is_store),
    .ex_funct3     (ex_funct3),
    .ex_alu_res    (ex_alu_res),
    .ex_store_data (ex_store_data),
    .ex_rd         (ex_rd),
    .ex_wb_en      (ex_wb_en),
    .stall         (stall),
    .mem           (mif.master),
    .wb_valid      (wb_valid),
    .wb_en         (wb_en),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .misalign      (misalign)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: RV32I access rules as plain arithmetic.
  function automatic int unsigned nbytes(input logic [2:0] f3);
    if (f3[1:0] == 2'd0) return 1;
    if (f3[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  function automatic bit is_mis(input logic [2:0] f3, input logic [31:0] a);
    return (a % nbytes(f3)) != 0;
  endfunction

  function automatic int unsigned lane_off(input logic [2:0] f3, input logic [31:0] a);
    int unsigned lo;
    lo = a & 3;
    return lo - (lo % nbytes(f3));
  endfunction

  function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rdata);
    int unsigned nb;
    logic [31:0] mask, v;
    nb = nbytes(f3);
    if (nb == 4) return rdata;
    mask = (32'd1 << (8 * nb)) - 32'd1;
    v = (rdata >> (8 * lane_off(f3, a))) & mask;
    if (f3 != 3'd4 && f3 != 3'd5 && ((v >> (8 * nb - 1)) & 32'd1) == 32'd1) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [31:0] strb_model(input logic [2:0] f3, input logic [31:0] a);
    return (((32'd1 << nbytes(f3)) - 32'd1) << lane_off(f3, a)) & 32'hF;
  endfunction

  function automatic logic [31:0] wdata_model(input logic [2:0] f3, input logic [31:0] d);
    case (nbytes(f3))
      1:       return (d & 32'hFF) * 32'h0101_0101;
      2:       return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  task automatic drive(input bit v, input bit ld, input bit st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd,
                       input bit we);
    ex_valid      = v;
    ex_is_load    = ld;
    ex_is_store   = st;
    ex_funct3     = f3;
    ex_alu_res    = a;
    ex_store_data = d;
    ex_rd         = rd;
    ex_wb_en      = we;
  endtask

  // Called just after a negedge; leaves ex_valid asserted so calls can run back to back.
  task automatic do_nonmem(input logic [4:0] rd, input bit we, input logic [31:0] res);
    drive(1'b1, 1'b0, 1'b0, 3'd0, res, $urandom, rd, we);
    check("nm_stall", 32'(stall), 32'd0);
    @(posedge clock);
    @(negedge clock);
    check("nm_wb_valid", 32'(wb_valid), 32'd1);
    check("nm_wb_en",    32'(wb_en), 32'(we));
    check("nm_wb_rd",    32'(wb_rd), 32'(rd));
    check("nm_wb_data",  wb_data, res);
    check("nm_misalign", 32'(misalign), 32'd0);
    check("nm_stall2",   32'(stall), 32'd0);
  endtask

  task automatic do_mem(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input logic [4:0] rd, input bit we,
                        input logic [31:0] rdata, input int unsigned waitn, input bit follow);
    logic [4:0]  jrd;
    logic [31:0] jres;
    jrd  = 5'($urandom);
    jres = $urandom;
    drive(1'b1, ld, !ld, f3, a, d, rd, we);
    check("m_stall_idle", 32'(stall), 32'd0);
    @(posedge clock);
    @(negedge clock);
`ifdef MISALIGN_TRAP_EN
    if (is_mis(f3, a)) begin
      ex_valid = 1'b0;
      check("trap_req",      32'(mif.mem_req), 32'd0);
      check("trap_stall",    32'(stall), 32'd0);
      check("trap_wb_valid", 32'(wb_valid), 32'd1);
      check("trap_wb_en",    32'(wb_en), 32'd0);
      check("trap_misalign", 32'(misalign), 32'd1);
      return;
    end
`endif
    if (follow) drive(1'b1, 1'b0, 1'b0, 3'd0, jres, 32'd0, jrd, 1'b1);
    else ex_valid = 1'b0;
    for (int i = 0; i <= int'(waitn); i++) begin
      check("m_stall",    32'(stall), 32'd1);
      check("m_req",      32'(mif.mem_req), 32'd1);
      check("m_wb_valid", 32'(wb_valid), 32'd0);
      check("m_addr",     mif.mem_addr, a & ~32'h3);
      check("m_we",       32'(mif.mem_we), 32'(!ld));
      if (!ld) begin
        check("m_wstrb", 32'(mif.mem_wstrb), strb_model(f3, a));
        check("m_wdata", mif.mem_wdata, wdata_model(f3, d));
      end
      mif.mem_ack   = (i == int'(waitn));
      mif.mem_rdata = (i == int'(waitn)) ? rdata : $urandom;
      @(posedge clock);
      @(negedge clock);
    end
    mif.mem_ack = 1'b0;
    check("m_done_stall", 32'(stall), 32'd0);
    check("m_done_req",   32'(mif.mem_req), 32'd0);
    check("m_wb_valid",   32'(wb_valid), 32'd1);
    check("m_wb_en",      32'(wb_en), 32'(ld && we));
    check("m_wb_rd",      32'(wb_rd), 32'(rd));
    check("m_misalign",   32'(misalign), 32'd0);
    if (ld) check("m_wb_data", wb_data, load_model(f3, a, rdata));
    if (follow) begin
      @(posedge clock);
      @(negedge clock);
      ex_valid = 1'b0;
      check("f_wb_valid", 32'(wb_valid), 32'd1);
      check("f_wb_rd",    32'(wb_rd), 32'(jrd));
      check("f_wb_data",  wb_data, jres);
    end
  endtask

  task automatic idle_cycle(input bit spurious_ack);
    ex_valid    = 1'b0;
    mif.mem_ack = spurious_ack;
    @(posedge clock);
    @(negedge clock);
    mif.mem_ack = 1'b0;
    check("idle_wb_valid", 32'(wb_valid), 32'd0);
    check("idle_req",      32'(mif.mem_req), 32'd0);
    check("idle_stall",    32'(stall), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    mif.mem_ack   = 1'b0;
    mif.mem_rdata = 32'd0;
    drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_stall",    32'(stall), 32'd0);
    check("rst_req",      32'(mif.mem_req), 32'd0);
    check("rst_we",       32'(mif.mem_we), 32'd0);
    check("rst_addr",     mif.mem_addr, 32'd0);
    check("rst_wstrb",    32'(mif.mem_wstrb), 32'd0);
    check("rst_wdata",    mif.mem_wdata, 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_en",    32'(wb_en), 32'd0);
    check("rst_wb_rd",    32'(wb_rd), 32'd0);
    check("rst_wb_data",  wb_data, 32'd0);
    check("rst_misalign", 32'(misalign), 32'd0);
    reset = 1'b0;
    idle_cycle(1'b0);

    do_nonmem(5'd5, 1'b1, 32'h0000_1234);
    idle_cycle(1'b0);
    do_mem(1'b1, 3'b000, 32'h103, 32'd0, 5'd7, 1'b1, 32'h80FF_0000, 0, 1'b0);
    check("lb_dir", wb_data, 32'hFFFF_FF80);
    do_mem(1'b1, 3'b100, 32'h103, 32'd0, 5'd7, 1'b1, 32'h80FF_0000, 0, 1'b0);
    check("lbu_dir", wb_data, 32'h0000_0080);
    do_mem(1'b0, 3'b001, 32'h202, 32'hDEAD_BEEF, 5'd3, 1'b1, 32'd0, 2, 1'b0);
    do_mem(1'b1, 3'b010, 32'h400, 32'd0, 5'd9, 1'b1, 32'hCAFE_F00D, 1, 1'b1);
    do_mem(1'b1, 3'b010, 32'h301, 32'd0, 5'd10, 1'b1, 32'h1357_9BDF, 1, 1'b0);
    for (int k = 0; k < 4; k++) do_nonmem(5'(k + 1), 1'b1, $urandom);
    idle_cycle(1'b1);
    idle_cycle(1'b1);

    // Reset while a request is outstanding.
    drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h500, 32'd0, 5'd4, 1'b1);
    @(posedge clock);
    @(negedge clock);
    ex_valid = 1'b0;
    check("rb_req", 32'(mif.mem_req), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("rb_req_drop",   32'(mif.mem_req), 32'd0);
    check("rb_stall_drop", 32'(stall), 32'd0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) idle_cycle(1'b0);
    do_nonmem(5'd11, 1'b1, 32'hA5A5_0001);
    idle_cycle(1'b0);

    for (int n = 0; n < 200; n++) begin
      int unsigned kind;
      logic [2:0]  f3;
      kind = $urandom_range(0, 9);
      if (kind < 3) begin
        do_nonmem(5'($urandom), 1'($urandom), $urandom);
      end else if (kind < 6) begin
        do_mem(1'b1, 3'($urandom), $urandom, $urandom, 5'($urandom), 1'($urandom),
               $urandom, $urandom_range(0, 3), 1'($urandom));
      end else if (kind < 9) begin
        f3 = 3'($urandom_range(0, 5));
        if (f3 >= 3'd4) f3 = f3 + 3'd2;
        do_mem(1'b0, f3, $urandom, $urandom, 5'($urandom), 1'($urandom),
               $urandom, $urandom_range(0, 3), 1'($urandom));
      end else begin
        idle_cycle(1'($urandom));
      end
    end
    idle_cycle(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
